sy_ppl_fet_pc: RTL and testbench

Instruction-fetch front end of the SiYuan pipeline, directly downstream of the pipeline control block. It owns the fetch PC, takes redirects and the run/kill commands from control, issues sequential 32-bit fetch requests to the I$ under a credit scheme, and buffers returned instructions in a small FIFO for the decode stage. It reports IF0 activity back to control so the pipeline-idle check can wait for in-flight fetches to drain.

---
 rtl/sy_ppl_fet_pc.sv | 187 ++++++++++++++++++
 tb/tb_sy_ppl_fet_pc.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sy_ppl_fet_pc.sv
// rtl/sy_ppl_fet_pc.sv - SiYuan instruction-fetch front end: fetch PC, credit-limited I$ requests, instruction buffer
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   ctrl_fet__set_en_i/_npc_i    redirect strobe and target (low two bits ignored)
//   ctrl_fet__act_i              fetch enable
//   ctrl_x__if0_kill_i           flush IF0
//   fet_ic__req_o/_addr_o        I$ request and 4-byte aligned address
//   ic_fet__gnt_i                I$ accepted the request
//   ic_fet__rvalid_i/_rdata_i/_err_i  I$ response in grant order
//   fet_dec__valid_o/_pc_o/_instr_o/_excp_o  head of the instruction buffer
//   dec_fet__ready_i             decode consumes the head entry
//   fet_ctrl__if0_act_o          fetch activity for the pipeline-idle check
module sy_ppl_fet_pc #(
    parameter int unsigned AWTH       = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ctrl_fet__set_en_i,
    input  logic [AWTH-1:0] ctrl_fet__set_npc_i,
    input  logic            ctrl_fet__act_i,
    input  logic            ctrl_x__if0_kill_i,
    output logic            fet_ic__req_o,
    output logic [AWTH-1:0] fet_ic__addr_o,
    input  logic            ic_fet__gnt_i,
    input  logic            ic_fet__rvalid_i,
    input  logic [31:0]     ic_fet__rdata_i,
    input  logic            ic_fet__err_i,
    output logic            fet_dec__valid_o,
    output logic [AWTH-1:0] fet_dec__pc_o,
    output logic [31:0]     fet_dec__instr_o,
    output logic            fet_dec__excp_o,
    input  logic            dec_fet__ready_i,
    output logic            fet_ctrl__if0_act_o
);
    localparam int unsigned     CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned     PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AWTH-1:0] PC_STEP = AWTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } st_e;

    st_e             st_q, st_d;
    logic [AWTH-1:0] pc_q, pc_d;
    logic [AWTH-1:0] rpc_q, rpc_d;
    logic [CW-1:0]   osd_q, osd_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [AWTH-1:0] buf_pc_q    [FIFO_DEPTH];
    logic [31:0]     buf_instr_q [FIFO_DEPTH];
    logic            buf_excp_q  [FIFO_DEPTH];

    logic            flush;
    logic            req;
    logic            grant;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic [AWTH-1:0] npc_al;

    assign flush       = ctrl_x__if0_kill_i | ctrl_fet__set_en_i;
    assign npc_al      = ctrl_fet__set_npc_i & ~AWTH'(3);
    // Outstanding plus buffered never exceeds the buffer size, so a
    // returning response always finds a free slot.
    assign credit_used = {1'b0, osd_q} + {1'b0, cnt_q};
    assign req         = (st_q == ST_RUN) & ctrl_fet__act_i & ~flush & (credit_used < DEPTH_C);
    assign grant       = req & ic_fet__gnt_i;
    // Responses are kept only when no stale responses remain to be drained
    // and no fault has frozen the stream.
    assign push        = ic_fet__rvalid_i & ~flush & (drop_q == '0) & (st_q != ST_HOLD);
    assign pop         = (cnt_q != '0) & dec_fet__ready_i & ~flush;

    always_comb begin
        pc_d     = pc_q;
        rpc_d    = rpc_q;
        osd_d    = osd_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        st_d     = st_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (grant && !ic_fet__rvalid_i) begin
            osd_d = osd_q + CW'(1);
        end else if (!grant && ic_fet__rvalid_i) begin
            osd_d = osd_q - CW'(1);
        end

        if (grant) begin
            pc_d = pc_q + PC_STEP;
        end

        if (flush) begin
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d   = osd_d;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (ctrl_fet__set_en_i) begin
                pc_d  = npc_al;
                rpc_d = npc_al;
                st_d  = ctrl_fet__act_i ? ST_RUN : ST_IDLE;
            end else begin
                st_d = ST_IDLE;
            end
        end else begin
            if (ic_fet__rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rpc_d    = rpc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (push && ic_fet__err_i) begin
                // Younger fetches after a fault are never delivered.
                st_d   = ST_HOLD;
                drop_d = osd_d;
            end else begin
                case (st_q)
                    ST_IDLE: if (ctrl_fet__act_i)  st_d = ST_RUN;
                    ST_RUN:  if (!ctrl_fet__act_i) st_d = ST_IDLE;
                    default: st_d = st_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q     <= ST_IDLE;
            pc_q     <= '0;
            rpc_q    <= '0;
            osd_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            st_q     <= st_d;
            pc_q     <= pc_d;
            rpc_q    <= rpc_d;
            osd_q    <= osd_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
                buf_excp_q[i]  <= 1'b0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]    <= rpc_q;
            buf_instr_q[wr_ptr_q] <= ic_fet__rdata_i;
            buf_excp_q[wr_ptr_q]  <= ic_fet__err_i;
        end
    end

    assign fet_ic__req_o       = req;
    assign fet_ic__addr_o      = pc_q;
    assign fet_dec__valid_o    = (cnt_q != '0);
    assign fet_dec__pc_o       = buf_pc_q[rd_ptr_q];
    assign fet_dec__instr_o    = buf_instr_q[rd_ptr_q];
    assign fet_dec__excp_o     = buf_excp_q[rd_ptr_q];
    assign fet_ctrl__if0_act_o = req | (osd_q != '0) | (cnt_q != '0);

endmodule

// File: tb/tb_sy_ppl_fet_pc.sv
// tb/tb_sy_ppl_fet_pc.sv - self-checking bench for sy_ppl_fet_pc with an I$ model and stream scoreboard
module tb_sy_ppl_fet_pc;
    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ctrl_fet__set_en_i;
    logic [63:0] ctrl_fet__set_npc_i;
    logic        ctrl_fet__act_i;
    logic        ctrl_x__if0_kill_i;
    logic        fet_ic__req_o;
    logic [63:0] fet_ic__addr_o;
    logic        ic_fet__gnt_i;
    logic        ic_fet__rvalid_i;
    logic [31:0] ic_fet__rdata_i;
    logic        ic_fet__err_i;
    logic        fet_dec__valid_o;
    logic [63:0] fet_dec__pc_o;
    logic [31:0] fet_dec__instr_o;
    logic        fet_dec__excp_o;
    logic        dec_fet__ready_i;
    logic        fet_ctrl__if0_act_o;

    always #5 clk_i = ~clk_i;

    sy_ppl_fet_pc #(.AWTH(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .ctrl_fet__set_en_i  (ctrl_fet__set_en_i),
        .ctrl_fet__set_npc_i (ctrl_fet__set_npc_i),
        .ctrl_fet__act_i     (ctrl_fet__act_i),
        .ctrl_x__if0_kill_i  (ctrl_x__if0_kill_i),
        .fet_ic__req_o       (fet_ic__req_o),
        .fet_ic__addr_o      (fet_ic__addr_o),
        .ic_fet__gnt_i       (ic_fet__gnt_i),
        .ic_fet__rvalid_i    (ic_fet__rvalid_i),
        .ic_fet__rdata_i     (ic_fet__rdata_i),
        .ic_fet__err_i       (ic_fet__err_i),
        .fet_dec__valid_o    (fet_dec__valid_o),
        .fet_dec__pc_o       (fet_dec__pc_o),
        .fet_dec__instr_o    (fet_dec__instr_o),
        .fet_dec__excp_o     (fet_dec__excp_o),
        .dec_fet__ready_i    (dec_fet__ready_i),
        .fet_ctrl__if0_act_o (fet_ctrl__if0_act_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] addr;
        int          ep;
    } pend_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        ex;
    } ent_t;

    pend_t       pend_q[$];   // I$ requests in flight, tagged with the stream epoch
    ent_t        exp_q[$];    // entries decode should see, in order
    logic [63:0] g_hist[$];   // granted addresses, cleared per scenario
    logic [63:0] m_fpc = '0;  // next fetch address
    int          m_st  = 0;   // 0 stopped, 1 fetching, 2 frozen by a fault
    int          epoch = 0;
    logic [63:0] err_addr = 64'h1;
    bit          err_rand = 0;

    bit          o_req, o_gnt, o_pop, o_valid, o_act;
    logic [63:0] o_addr;
    ent_t        o_ent;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    function automatic bit errf(input logic [63:0] a);
        logic [31:0] h;
        h = memf(a);
        return (a == err_addr) || (err_rand && (h[4:0] == 5'd0));
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare outputs,
    // then advance the reference model. gmode/rmode: 0 never, 1 always,
    // 2 random, 3 (rvalid only) when two responses are pending.
    task automatic step(input bit act, input bit sen, input logic [63:0] npc, input bit kill,
                        input bit rdy, input int gmode, input int rmode);
        bit    rv, flush, exp_req, exp_act, g, useful, rerr;
        int    osd_m;
        pend_t rsp, p;
        ent_t  e;
        flush = sen | kill;
        osd_m = pend_q.size();
        rv    = 0;
        if (pend_q.size() > 0) begin
            case (rmode)
                1:       rv = 1;
                2:       rv = ($urandom_range(0, 2) != 0);
                3:       rv = (pend_q.size() == 2);
                default: rv = 0;
            endcase
        end
        ctrl_fet__act_i     = act;
        ctrl_fet__set_en_i  = sen;
        ctrl_fet__set_npc_i = npc;
        ctrl_x__if0_kill_i  = kill;
        dec_fet__ready_i    = rdy;
        ic_fet__rvalid_i    = rv;
        ic_fet__gnt_i       = 1'b0;
        rsp.addr = '0;
        rsp.ep   = -1;
        rerr     = 0;
        if (rv) begin
            rsp             = pend_q.pop_front();
            rerr            = errf(rsp.addr);
            ic_fet__rdata_i = memf(rsp.addr);
            ic_fet__err_i   = rerr;
        end else begin
            ic_fet__rdata_i = $urandom;
            ic_fet__err_i   = 1'($urandom_range(0, 1));
        end
        #1;
        exp_req = (m_st == 1) && act && !flush && ((osd_m + exp_q.size()) < DEPTH);
        exp_act = exp_req || (osd_m != 0) || (exp_q.size() != 0);
        total++;
        if (fet_ic__req_o !== exp_req) begin
            bad++;
            $display("FAIL req t=%0t got=%b exp=%b", $time, fet_ic__req_o, exp_req);
        end
        total++;
        if (fet_ic__addr_o !== m_fpc) begin
            bad++;
            $display("FAIL addr t=%0t got=%h exp=%h", $time, fet_ic__addr_o, m_fpc);
        end
        total++;
        if (fet_dec__valid_o !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL valid t=%0t got=%b exp=%b", $time, fet_dec__valid_o, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            total++;
            if ({fet_dec__pc_o, fet_dec__instr_o, fet_dec__excp_o} !== {e.pc, e.ins, e.ex}) begin
                bad++;
                $display("FAIL head t=%0t got=%h/%h/%b exp=%h/%h/%b", $time, fet_dec__pc_o,
                         fet_dec__instr_o, fet_dec__excp_o, e.pc, e.ins, e.ex);
            end
        end
        total++;
        if (fet_ctrl__if0_act_o !== exp_act) begin
            bad++;
            $display("FAIL if0_act t=%0t got=%b exp=%b", $time, fet_ctrl__if0_act_o, exp_act);
        end
        case (gmode)
            1:       g = 1;
            2:       g = 1'($urandom_range(0, 1));
            default: g = 0;
        endcase
        ic_fet__gnt_i = g;
        o_req   = fet_ic__req_o;
        o_addr  = fet_ic__addr_o;
        o_gnt   = g && exp_req;
        o_valid = fet_dec__valid_o;
        o_act   = fet_ctrl__if0_act_o;
        o_pop   = fet_dec__valid_o && rdy && !flush;
        o_ent.pc  = fet_dec__pc_o;
        o_ent.ins = fet_dec__instr_o;
        o_ent.ex  = fet_dec__excp_o;

        if (flush) begin
            exp_q.delete();
            epoch++;
            if (sen) begin
                m_fpc = npc & ~64'h3;
                m_st  = act ? 1 : 0;
            end else begin
                m_st = 0;
            end
        end else begin
            if ((exp_q.size() != 0) && rdy) void'(exp_q.pop_front());
            if (o_gnt) begin
                p.addr = m_fpc;
                p.ep   = epoch;
                pend_q.push_back(p);
                g_hist.push_back(m_fpc);
                m_fpc = m_fpc + 64'd4;
            end
            useful = rv && (rsp.ep == epoch) && (m_st != 2);
            if (useful) begin
                e.pc  = rsp.addr;
                e.ins = memf(rsp.addr);
                e.ex  = rerr;
                exp_q.push_back(e);
            end
            if (useful && rerr)          m_st = 2;
            else if (m_st == 0 && act)   m_st = 1;
            else if (m_st == 1 && !act)  m_st = 0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        ctrl_fet__set_en_i = 0; ctrl_fet__set_npc_i = '0; ctrl_fet__act_i = 1;
        ctrl_x__if0_kill_i = 0; ic_fet__gnt_i = 0; ic_fet__rvalid_i = 0;
        ic_fet__rdata_i = '0; ic_fet__err_i = 0; dec_fet__ready_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        total++;
        if ({fet_ic__req_o, fet_dec__valid_o, fet_dec__excp_o, fet_ctrl__if0_act_o} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b%b exp=0000", fet_ic__req_o, fet_dec__valid_o,
                     fet_dec__excp_o, fet_ctrl__if0_act_o);
        end
        total++;
        if ({fet_ic__addr_o, fet_dec__pc_o, fet_dec__instr_o} !== 160'b0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", fet_ic__addr_o, fet_dec__pc_o, fet_dec__instr_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        step(0, 0, '0, 0, 1, 1, 1);
    endtask

    task automatic test_sequential();
        logic [63:0] nxt = 64'h8000_0000;
        logic [63:0] dpc = 64'h8000_0000;
        int pops = 0;
        step(1, 1, 64'h8000_0000, 0, 1, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, '0, 0, 1, 1, 1);
            total++;
            if (o_act !== 1'b1) begin
                bad++;
                $display("FAIL seq_if0_act cyc=%0d got=%b exp=1", i, o_act);
            end
            if (o_gnt) begin
                total++;
                if (o_addr !== nxt) begin
                    bad++;
                    $display("FAIL seq_addr got=%h exp=%h", o_addr, nxt);
                end
                nxt += 64'd4;
            end
            if (o_pop) begin
                total++;
                if (o_ent.pc !== dpc || o_ent.ins !== memf(dpc)) begin
                    bad++;
                    $display("FAIL seq_dec got=%h/%h exp=%h/%h", o_ent.pc, o_ent.ins, dpc, memf(dpc));
                end
                dpc += 64'd4;
                pops++;
            end
        end
        total++;
        if (pops < 8) begin
            bad++;
            $display("FAIL seq_count got=%0d exp>=8", pops);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] dpc = 64'h1000;
        int pops = 0;
        step(1, 1, 64'h1000, 0, 0, 1, 1);
        g_hist.delete();
        for (int i = 0; i < 8; i++) step(1, 0, '0, 0, 0, 1, 1);
        total++;
        if (g_hist.size() != 2 || o_req !== 1'b0) begin
            bad++;
            $display("FAIL bp_grants got=%0d req=%b exp=2 req=0", g_hist.size(), o_req);
        end
        for (int i = 0; i < 14; i++) begin
            step(1, 0, '0, 0, 1, 1, 1);
            if (o_pop) begin
                total++;
                if (o_ent.pc !== dpc) begin
                    bad++;
                    $display("FAIL bp_order got=%h exp=%h", o_ent.pc, dpc);
                end
                dpc += 64'd4;
                pops++;
            end
        end
        total++;
        if (pops < 6) begin
            bad++;
            $display("FAIL bp_resume got=%0d exp>=6", pops);
        end
    endtask

    task automatic test_kill();
        step(1, 1, 64'h2000, 0, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 0);
        step(1, 0, '0, 1, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 1);
        total++;
        if (o_req !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL kill_idle got req=%b valid=%b exp=0/0", o_req, o_valid);
        end
        step(0, 0, '0, 0, 1, 1, 1);
        total++;
        if (o_valid !== 1'b0 || o_act !== 1'b1) begin
            bad++;
            $display("FAIL kill_drain got valid=%b act=%b exp=0/1", o_valid, o_act);
        end
        step(0, 0, '0, 0, 1, 1, 1);
        total++;
        if (o_valid !== 1'b0 || o_act !== 1'b0) begin
            bad++;
            $display("FAIL kill_done got valid=%b act=%b exp=0/0", o_valid, o_act);
        end
        step(0, 1, 64'h3000, 0, 1, 1, 1);
    endtask

    task automatic test_redirect();
        bit seen = 0;
        step(1, 1, 64'h40, 0, 1, 1, 0);
        g_hist.delete();
        step(1, 0, '0, 0, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 0);
        step(1, 1, 64'h100, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, '0, 0, 1, 1, 1);
            if (o_pop && !seen) begin
                seen = 1;
                total++;
                if (g_hist.size() < 3 || o_ent.pc !== 64'h100 || o_ent.ins !== memf(g_hist[2])) begin
                    bad++;
                    $display("FAIL redir_first got=%h/%h exp=100/%h", o_ent.pc, o_ent.ins, memf(64'h100));
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL redir_none got=0 exp=1 entries");
        end
    endtask

    task automatic test_fault();
        bit seen = 0;
        int late = 0;
        err_addr = 64'h204;
        step(1, 1, 64'h200, 0, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, '0, 0, 1, 1, (i < 9) ? 3 : 1);
            if (seen && o_req) late++;
            if (o_pop && o_ent.pc === 64'h204) begin
                seen = 1;
                total++;
                if (o_ent.ex !== 1'b1) begin
                    bad++;
                    $display("FAIL fault_excp got=%b exp=1", o_ent.ex);
                end
            end
        end
        total++;
        if (!seen || late != 0 || o_act !== 1'b0) begin
            bad++;
            $display("FAIL fault_hold got seen=%b reqs=%0d act=%b exp=1/0/0", seen, late, o_act);
        end
        err_addr = 64'h1;
        step(1, 1, 64'h300, 0, 1, 1, 1);
        step(1, 0, '0, 0, 1, 1, 1);
        total++;
        if (o_req !== 1'b1 || o_addr !== 64'h300) begin
            bad++;
            $display("FAIL fault_resume got req=%b addr=%h exp=1/300", o_req, o_addr);
        end
    endtask

    task automatic test_wrap();
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 1);
        g_hist.delete();
        for (int i = 0; i < 6; i++) step(1, 0, '0, 0, 1, 1, 1);
        total++;
        if (g_hist.size() < 2 || g_hist[0] !== 64'hFFFF_FFFF_FFFF_FFFC || g_hist[1] !== 64'h0) begin
            bad++;
            $display("FAIL wrap got n=%0d exp FFFFFFFFFFFFFFFC then 0", g_hist.size());
        end
    endtask

    task automatic test_random();
        bit need = 0;
        bit act, sen, kill;
        logic [63:0] npc;
        err_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            act  = ($urandom_range(0, 7) != 0);
            sen  = need || ($urandom_range(0, 40) == 0) || (m_st == 2 && $urandom_range(0, 5) == 0);
            kill = ($urandom_range(0, 50) == 0);
            case ($urandom_range(0, 3))
                0:       npc = {$urandom, $urandom};
                1:       npc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: npc = {32'h0, $urandom};
            endcase
            step(act, sen, npc, kill, ($urandom_range(0, 3) != 0), 2, 2);
            need = kill && !sen;
        end
        err_rand = 0;
        if (need) step(1, 1, 64'h4000, 0, 1, 2, 2);
    endtask

    task automatic test_async_reset();
        step(1, 1, 64'h5000, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 1, 2);
        #2;
        rst_i = 1'b0;
        #1;
        total++;
        if ({fet_ic__req_o, fet_dec__valid_o, fet_ctrl__if0_act_o} !== 3'b0 ||
            {fet_ic__addr_o, fet_dec__pc_o, fet_dec__instr_o, fet_dec__excp_o} !== 161'b0) begin
            bad++;
            $display("FAIL async_reset got req=%b valid=%b act=%b addr=%h exp=0", fet_ic__req_o,
                     fet_dec__valid_o, fet_ctrl__if0_act_o, fet_ic__addr_o);
        end
        pend_q.delete();
        exp_q.delete();
        epoch++;
        m_fpc = '0;
        m_st  = 0;
        ic_fet__rvalid_i = 0;
        ic_fet__gnt_i    = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 20; i++) step(1, 0, '0, 0, 1, 2, 2);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_kill();
        test_redirect();
        test_fault();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
